spike_event_encoder: RTL and testbench
======================================

// Module: spike_event_encoder
// PURPOSE
//   Downstream stage of the Izhikevich neuron. Samples the membrane potential v each
//   enabled cycle and detects spikes as a large downward jump (v(t-1) - v(t) >= JUMP_TH),
//   which is the signature of the after-spike reset to c. Each spike becomes a timestamped
//   event with its inter-spike interval (ISI). Events are buffered in a first-word-
//   fall-through (FWFT) FIFO behind a valid/ready handshake toward the readout/AER logic.
// PARAMETERS
//   JUMP_TH   16'sd40  minimum v(t-1)-v(t) drop, signed, that counts as a spike
//   REFRAC    4        enabled samples after a spike during which detection is masked
//   TS_W      16       width of timestamp counter and ISI field
//   DEPTH     8        FIFO depth in events, power of two, >= 2
//   CNT_W     8        width of the saturating drop counter
// PORTS
//   clk         in   1            rising-edge clock
//   reset       in   1            asynchronous, active-high reset
//   en          in   1            sample strobe; v is valid and sampled when en=1
//   v           in   16 signed    membrane potential from the neuron
//   spike_pulse out  1            one-cycle pulse per accepted spike detection
//   evt_valid   out  1            FIFO head holds an event
//   evt_ready   in   1            consumer accepts the head event when evt_valid=1
//   evt_ts      out  TS_W         timestamp of the head event
//   evt_isi     out  TS_W         ISI of the head event; all-ones marks first spike
//   fifo_count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
//   drop_count  out  CNT_W        number of spikes lost to a full FIFO, saturating
// BEHAVIOUR
//   Reset values: v_prev=0, prev_ok=0, ts=0, refrac_cnt=0, have_last=0, last_ts=0,
//     spike_pulse=0, FIFO empty (evt_valid=0, fifo_count=0), drop_count=0.
//     evt_ts and evt_isi read 0 while the FIFO is empty.
//   Behaviour on en=1 at a clock edge:
//     - diff = v_prev - v, computed as a signed 17-bit value with no overflow.
//     - det = prev_ok & (diff >= JUMP_TH) & (refrac_cnt==0).
//     - Update v_prev<=v, prev_ok<=1, ts<=ts+1 (wraps mod 2^TS_W).
//     - If det: refrac_cnt<=REFRAC, spike_pulse<=1, last_ts<=ts, have_last<=1.
//       Build the event as {ts_pre, isi}. ts_pre is ts before the increment.
//       isi = have_last ? (ts_pre - last_ts) mod 2^TS_W : all-ones.
//     - If not det: refrac_cnt decrements when nonzero, and spike_pulse<=0.
//   Behaviour on en=0: all state holds, and spike_pulse<=0.
//     - A spike is therefore a single-cycle pulse that follows the detecting edge.
//   The first sample after reset never detects, because prev_ok=0.
//   FIFO:
//     - Push on det. Pop when evt_valid & evt_ready.
//     - FWFT: an event pushed into an empty FIFO at edge k is visible with evt_valid=1
//       right after edge k.
//     - Full with no pop: the push is dropped and drop_count increments, saturating at
//       2^CNT_W-1. The spike still updates spike_pulse, last_ts and refractory.
//     - Full with simultaneous pop: the push is accepted and the count stays DEPTH.
//     - Empty with push and evt_ready=1: the event is written. It is not popped that
//       cycle, because evt_valid was 0.
//     - Read/write pointers wrap mod DEPTH, and the head stays stable while
//       evt_valid & !evt_ready.
//   Asserting reset mid-operation clears the FIFO (pending events lost), the counters
//   and the history immediately.
// TESTING
//   1 Reset, then en=1 with v=-70 held 20 cycles -> no spike_pulse, evt_valid=0, ts=20.
//   2 Sequence v=-70,-40,20,-65 with en=1 each cycle -> spike_pulse one cycle after the
//     -65 sample; event ts=3, isi=16'hFFFF, evt_valid=1.
//   3 Two drops at ts=3 and ts=13, REFRAC=4 -> second event isi=10.
//     A drop 2 samples after the first is ignored (refractory).
//   4 evt_ready=0 while 10 spikes arrive, spaced > REFRAC -> fifo_count=8, drop_count=2,
//     the head stays the first event; then evt_ready=1 drains 8 events in order.
//   5 FIFO full, simultaneous spike and pop -> count stays 8, drop_count unchanged,
//     newest event at the tail.
//   6 Reset asserted asynchronously with 5 events queued -> evt_valid=0, fifo_count=0
//     and drop_count=0 before the next edge. The first spike after release gets isi=FFFF.
//   7 en toggled 1/0 with a drop sampled on en=1 cycles -> ts advances only on en=1.
//     Drops while en=0 are not sampled.

Source files
------------

// File: rtl/spike_event_encoder.sv
// Spike detector for the Izhikevich neuron: flags large downward jumps in v as spikes,
// timestamps them with their inter-spike interval and queues them in a FWFT FIFO.
module spike_event_encoder #(
    parameter logic signed [15:0] JUMP_TH = 16'sd40,
    parameter int                 REFRAC  = 4,
    parameter int                 TS_W    = 16,
    parameter int                 DEPTH   = 8,
    parameter int                 CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic signed [15:0]       v,
    output logic                     spike_pulse,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_ts,
    output logic [TS_W-1:0]          evt_isi,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(REFRAC + 2);

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [TS_W-1:0] isi;
    } evt_t;

    logic signed [15:0] v_prev;
    logic               prev_ok;
    logic [TS_W-1:0]    ts;
    logic [RW-1:0]      refrac_cnt;
    logic               have_last;
    logic [TS_W-1:0]    last_ts;

    evt_t               mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;

    logic signed [16:0] diff;
    logic               det, full, push, pop;
    evt_t               new_evt;

    // 17-bit difference so the extremes of v cannot overflow
    assign diff = {v_prev[15], v_prev} - {v[15], v};
    assign det  = en & prev_ok & (diff >= $signed({JUMP_TH[15], JUMP_TH})) & (refrac_cnt == '0);

    assign new_evt.ts  = ts;
    assign new_evt.isi = have_last ? ts - last_ts : '1;

    assign evt_valid = (fifo_count != '0);
    assign full      = (fifo_count == (AW+1)'(DEPTH));
    assign pop       = evt_valid & evt_ready;
    // a full FIFO still takes the event when the head leaves on the same edge
    assign push      = det & (~full | pop);

    assign evt_ts  = evt_valid ? mem[rd_ptr].ts  : '0;
    assign evt_isi = evt_valid ? mem[rd_ptr].isi : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_prev      <= '0;
            prev_ok     <= 1'b0;
            ts          <= '0;
            refrac_cnt  <= '0;
            have_last   <= 1'b0;
            last_ts     <= '0;
            spike_pulse <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            drop_count  <= '0;
        end else begin
            spike_pulse <= det;
            if (en) begin
                v_prev  <= v;
                prev_ok <= 1'b1;
                ts      <= ts + 1'b1;
                if (det) begin
                    refrac_cnt <= RW'(REFRAC);
                    last_ts    <= ts;
                    have_last  <= 1'b1;
                end else if (refrac_cnt != '0) begin
                    refrac_cnt <= refrac_cnt - 1'b1;
                end
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!push && pop) fifo_count <= fifo_count - 1'b1;
            if (det && !push && drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_evt;
    end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Randomized bench for spike_event_encoder: a sample-history model predicts events into
// a scoreboard queue; a negedge monitor checks the FIFO head, occupancy and counters.
module tb_spike_event_encoder;
    localparam int REFRAC = 4;
    localparam int DEPTH  = 8;
    localparam int TH     = 40;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               en = 1'b0;
    logic signed [15:0] v = '0;
    logic               evt_ready = 1'b0;
    logic               spike_pulse, evt_valid;
    logic [15:0]        evt_ts, evt_isi;
    logic [3:0]         fifo_count;
    logic [7:0]         drop_count;

    spike_event_encoder #(.JUMP_TH(16'sd40), .REFRAC(REFRAC), .TS_W(16), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .v(v), .spike_pulse(spike_pulse),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ts(evt_ts), .evt_isi(evt_isi),
        .fifo_count(fifo_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: full sample history since reset, index = timestamp
    logic signed [15:0] samples[$];
    logic [31:0]        exp_q[$];
    bit                 m_have;
    int                 m_last;
    int                 cur_occ, cur_drop, nxt_occ, nxt_drop;
    bit                 cur_pulse, nxt_pulse;
    bit                 mon_on = 1'b0;

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_clear();
        samples.delete();
        exp_q.delete();
        m_have = 0; m_last = 0;
        cur_occ = 0; cur_drop = 0; cur_pulse = 0;
        nxt_occ = 0; nxt_drop = 0; nxt_pulse = 0;
    endtask

    // drive one cycle of inputs and predict the outcome of the coming edge
    task automatic step(input bit e, input int vv, input bit r);
        bit det, pop, acc;
        int n;
        logic [15:0] isi;
        @(posedge clk); #1;
        cur_occ = nxt_occ; cur_drop = nxt_drop; cur_pulse = nxt_pulse;
        en = e; v = 16'(vv); evt_ready = r;
        pop = (cur_occ > 0) && r;
        det = 0; acc = 0;
        if (e) begin
            n = samples.size();
            if (n > 0 && (int'(samples[n-1]) - vv >= TH) && (!m_have || n - m_last > REFRAC))
                det = 1;
            samples.push_back(16'(vv));
            if (det) begin
                isi = m_have ? 16'(n - m_last) : 16'hFFFF;
                acc = (cur_occ < DEPTH) || pop;
                if (acc) exp_q.push_back({16'(n), isi});
                else if (cur_drop < 255) nxt_drop = cur_drop + 1;
                m_have = 1; m_last = n;
            end
        end
        nxt_pulse = det;
        nxt_occ = cur_occ + int'(acc) - int'(pop);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        mon_on = 0;
        reset = 1'b1;
        en = 0; evt_ready = 0;
        model_clear();
        #1;
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_spike_pulse", spike_pulse, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        mon_on = 1;
    endtask

    task automatic spike_pair(input bit r);
        step(1, 0, r);
        step(1, -60, r);
        for (int i = 0; i < REFRAC; i++) step(1, -60, r);
    endtask

    // monitor: compare DUT against model mid-cycle
    always @(negedge clk) begin
        if (mon_on) begin
            chk("spike_pulse", spike_pulse, cur_pulse);
            chk("fifo_count", fifo_count, cur_occ);
            chk("drop_count", drop_count, cur_drop);
            chk("evt_valid", evt_valid, cur_occ > 0);
            if (evt_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    chk("evt_ts", evt_ts, exp_q[0][31:16]);
                    chk("evt_isi", evt_isi, exp_q[0][15:0]);
                    if (evt_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("empty_ts", evt_ts, 0);
                chk("empty_isi", evt_isi, 0);
            end
        end
    end

    initial begin
        model_clear();
        #2;
        chk("init_evt_valid", evt_valid, 0);
        chk("init_fifo_count", fifo_count, 0);
        do_reset();

        // steady potential: no spikes
        for (int i = 0; i < 20; i++) step(1, -70, 1);

        // canonical spike: event ts=3, isi=FFFF
        do_reset();
        step(1, -70, 0); step(1, -40, 0); step(1, 20, 0); step(1, -65, 0);
        step(0, -65, 0);
        chk("first_evt_ts", evt_ts, 3);
        chk("first_evt_isi", evt_isi, 16'hFFFF);
        // drop during refractory ignored, next spike at 13 gives isi 10
        step(1, 0, 0); step(1, -60, 0);
        for (int i = 0; i < 6; i++) step(1, -60, 0);
        step(1, 0, 0); step(1, -60, 0);
        for (int i = 0; i < 6; i++) step(1, -60, 1);

        // overflow: 10 spikes with ready low, then drain
        do_reset();
        step(1, -60, 0);
        for (int i = 0; i < 10; i++) spike_pair(0);
        step(0, 0, 0);
        chk("full_count", fifo_count, DEPTH);
        chk("full_drops", drop_count, 2);
        chk("full_head_ts", evt_ts, 2);
        // full with simultaneous spike and pop
        step(1, 0, 0);
        step(1, -60, 1);
        step(1, -60, 0);
        for (int i = 0; i < 12; i++) step(1, -60, 1);

        // async reset with events queued, then first spike isi=FFFF
        for (int i = 0; i < 5; i++) spike_pair(0);
        do_reset();
        step(1, -70, 1); step(1, 0, 1); step(1, -50, 1); step(1, -50, 1);

        // en toggling: drops presented while en=0 are not sampled
        for (int i = 0; i < 40; i++) step(i % 2 == 0, (i % 4 == 1) ? -100 : ((i % 8 < 4) ? 0 : -60), 1);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 140)) - 100,
                 (i / 500) % 2 == 0 ? $urandom_range(0, 2) != 0 : $urandom_range(0, 5) == 0);
        for (int i = 0; i < 30; i++) step(0, 0, 1);
        mon_on = 0;
        chk("final_scoreboard", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
